// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath/memory.
// The master side (the sequencer) receives the opcode, halt and memory
// handshake and drives every datapath strobe plus the debug/status outputs.
interface multicycle_ctrl_if;
    logic [1:0] op;
    logic       halt;
    logic       mem_ready;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCSrc;
    logic       ALUSrc;
    logic       RegDst;
    logic       RegWrite;
    logic       MemtoReg;
    logic       instr_done;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        input  op, halt, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrc,
               RegDst, RegWrite, MemtoReg, instr_done, bus_err, state
    );

    modport slave (
        output op, halt, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrc,
               RegDst, RegWrite, MemtoReg, instr_done, bus_err, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the 4-opcode core (add, lw, sw, j). One memory
// port is shared between fetch and data access; memory states hold their
// strobes until mem_ready and trap to ERROR after MAX_WAIT low cycles.
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExec   = 4'd3,
        StWbR    = 4'd4,
        StAddr   = 4'd5,
        StMemRd  = 4'd6,
        StWbM    = 4'd7,
        StMemWr  = 4'd8,
        StJump   = 4'd9,
        StError  = 4'd15
    } stateT;

    stateT            stateQ, stateD;
    logic [1:0]       opQ, opD;
    logic [CntW-1:0]  waitQ, waitD;
    logic             busErrQ;
    stateT            boundaryNext;
    logic             waitExpired;
    logic             memState;

    // halt is only honoured at an instruction boundary
    assign boundaryNext = bus.halt ? StIdle : StFetch;
    // this cycle would be the MAX_WAIT-th consecutive low cycle
    assign waitExpired  = (waitQ == CntW'(MAX_WAIT - 1));
    assign memState     = (stateQ == StFetch) || (stateQ == StMemRd) || (stateQ == StMemWr);

    assign bus.state   = stateQ;
    assign bus.bus_err = busErrQ;

    // Next-state and per-state datapath strobes
    always_comb begin
        stateD         = stateQ;
        opD            = opQ;
        bus.IorD       = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.PCSrc      = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.RegDst     = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.instr_done = 1'b0;
        case (stateQ)
            StIdle: begin
                if (!bus.halt) stateD = StFetch;
            end
            StFetch: begin
                bus.MemRead = 1'b1;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    stateD      = StDecode;
                end else if (waitExpired) begin
                    stateD = StError;
                end
            end
            StDecode: begin
                opD = bus.op;
                case (bus.op)
                    2'b00:   stateD = StExec;
                    2'b01:   stateD = StAddr;
                    2'b10:   stateD = StAddr;
                    default: stateD = StJump;
                endcase
            end
            StExec: begin
                stateD = StWbR;
            end
            StWbR: begin
                bus.RegDst     = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                stateD         = boundaryNext;
            end
            StAddr: begin
                bus.ALUSrc = 1'b1;
                // use the opcode captured in DECODE, not the live IR field
                stateD     = (opQ == 2'b01) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
                bus.ALUSrc  = 1'b1;
                if (bus.mem_ready)  stateD = StWbM;
                else if (waitExpired) stateD = StError;
            end
            StWbM: begin
                bus.RegWrite   = 1'b1;
                bus.MemtoReg   = 1'b1;
                bus.instr_done = 1'b1;
                stateD         = boundaryNext;
            end
            StMemWr: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                bus.ALUSrc   = 1'b1;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    stateD         = boundaryNext;
                end else if (waitExpired) begin
                    stateD = StError;
                end
            end
            StJump: begin
                bus.PCWrite    = 1'b1;
                bus.PCSrc      = 1'b1;
                bus.instr_done = 1'b1;
                stateD         = boundaryNext;
            end
            StError: begin
                stateD = StError;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    // Wait counter: counts consecutive low cycles while parked in a memory state,
    // zero whenever the state changes so every memory state starts fresh
    always_comb begin
        waitD = '0;
        if (memState && !bus.mem_ready && (stateD == stateQ)) begin
            waitD = waitQ + CntW'(1);
        end
    end

    // State, latched opcode, wait counter and sticky bus error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ  <= StIdle;
            opQ     <= 2'b00;
            waitQ   <= '0;
            busErrQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            opQ    <= opD;
            waitQ  <= waitD;
            if (stateD == StError) busErrQ <= 1'b1;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the 8-bit, 4-opcode core (add, lw, sw, j). It replaces single-cycle decode with a state machine that shares one memory port between instruction fetch and data access. It generates per-state datapath strobes, handshakes with memory through `mem_ready`, and traps stalled memory accesses with a timeout. It sits between the IR opcode field and the datapath muxes and enables.

## Interface
- `MAX_WAIT`, 15: maximum consecutive `mem_ready`-low cycles tolerated in a memory state before trapping (≥1).
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; forces `IDLE`, clears the wait counter and `bus_err`.
- `op` input 2: IR[7:6] from the IR register. Sampled only in `DECODE`. 00=add, 01=lw, 10=sw, 11=j.
- `halt` input 1: request to stop at an instruction boundary.
- `mem_ready` input 1: memory completes the current access in this cycle.
- `IorD` output 1: memory address select (0=PC, 1=ALU result).
- `MemRead`, `MemWrite` outputs 1: memory strobes, held until `mem_ready`.
- `IRWrite` output 1: load IR.
- `PCWrite` output 1: load PC.
- `PCSrc` output 1: PC source (0=PC+1, 1=jump target).
- `ALUSrc` output 1: ALU B input (0=register, 1=immediate).
- `RegDst`, `RegWrite`, `MemtoReg` outputs 1: register-file write controls.
- `instr_done` output 1: one-cycle pulse on the final cycle of each instruction.
- `bus_err` output 1: sticky timeout flag.
- `state` output 4: current state encoding, for debug.

## Operation
- States and encoding: `IDLE`=0, `FETCH`=1, `DECODE`=2, `EXEC`=3, `WB_R`=4, `ADDR`=5, `MEMRD`=6, `WB_M`=7, `MEMWR`=8, `JUMP`=9, `ERROR`=15. Encodings 10–14 are unused and fall back to `IDLE`.
- `IDLE`: all outputs 0.
  - `halt`=0 → `FETCH`; otherwise stay.
- `FETCH`: IorD=0, MemRead=1.
  - IRWrite=PCWrite=`mem_ready`, with PCSrc=0.
  - On ready → `DECODE`.
- `DECODE`: no strobes.
  - op 00 → `EXEC`; op 01 or 10 → `ADDR`; op 11 → `JUMP`.
- `EXEC`: ALUSrc=0 → `WB_R`.
- `WB_R`: RegDst=1, RegWrite=1, instr_done=1 → boundary.
- `ADDR`: ALUSrc=1.
  - op 01 → `MEMRD`; op 10 → `MEMWR`.
  - The op is latched at `DECODE`; later IR changes are ignored.
- `MEMRD`: IorD=1, MemRead=1, ALUSrc=1.
  - On ready → `WB_M`.
- `WB_M`: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1 → boundary.
- `MEMWR`: IorD=1, MemWrite=1, ALUSrc=1.
  - On ready: instr_done=1 → boundary.
- `JUMP`: PCWrite=1, PCSrc=1, instr_done=1 → boundary.
- Boundary transition: `halt`=1 → `IDLE`; otherwise → `FETCH`. `halt` is ignored mid-instruction.
- Wait counter (width clog2(MAX_WAIT+1)):
  - Cleared on entry to `FETCH`, `MEMRD` and `MEMWR`.
  - Increments each cycle in those states while `mem_ready`=0.
  - Reaching `MAX_WAIT` → `ERROR` at the next edge; no strobe is asserted that cycle beyond the state's held MemRead/MemWrite.
- `ERROR`: all strobes 0 and `bus_err`=1.
  - Exit only by reset; `halt` and `mem_ready` are ignored.
- Any output not listed for a state is 0.
- Strobes are combinational from state (plus `mem_ready` where stated).
- `bus_err` and `state` are registered.

## Timing
- Reset (async assert): state=`IDLE` immediately. All outputs 0, `bus_err`=0, counter=0.
- Latency with zero-wait memory, `FETCH` through the boundary cycle:
  - add 4 cycles (F, D, EXEC, WB_R)
  - lw 5 cycles (F, D, ADDR, MEMRD, WB_M)
  - sw 4 cycles (F, D, ADDR, MEMWR)
  - j 3 cycles (F, D, JUMP)
- Each `mem_ready`-low cycle in a memory state adds exactly one cycle.
- `mem_ready` is meaningful only in memory states and is ignored elsewhere.
- `mem_ready`=1 in the same cycle the counter reaches `MAX_WAIT`−1 still completes normally. Trap condition: `MAX_WAIT` consecutive low cycles.
- Reset asserted mid-instruction or mid-wait: abort immediately with no strobe pulse; PC and IR are not written.
- After reset release with `halt`=0: first `FETCH` at the next edge.

## Test plan
- Reset, then `halt`=0, op=00, `mem_ready`=1 → state sequence 0,1,2,3,4,1. IRWrite and PCWrite high in cycle 1 only. RegDst=RegWrite=1 in `WB_R`. One instr_done pulse.
- op=01 with 3 wait cycles in `MEMRD` → MemRead and IorD held 4 cycles. `WB_M` asserts RegWrite and MemtoReg. Total 8 cycles.
- op=10 and op=11 back-to-back, zero-wait → MemWrite exactly 1 cycle with IorD=1. `JUMP` asserts PCWrite=PCSrc=1. instr_done at cycles 4 and 7.
- `mem_ready` held 0 in `FETCH`, `MAX_WAIT`=15 → `ERROR` after 15 low cycles. `bus_err`=1, all strobes 0. Still there after 20 further cycles with `mem_ready`=1. Reset clears.
- `halt`=1 raised during `EXEC` of an add → completes `WB_R`, enters `IDLE` (not `FETCH`). `halt` drop → `FETCH` next edge.
- Reset pulsed during `MEMWR` wait → state=0 asynchronously. MemWrite deasserts the same cycle. Counter and `bus_err` are 0 afterwards.
